// File: rtl/shared_mem_arb_pkg.sv
// Shared constants and types for the round-robin shared-memory arbiter.
package shared_mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W  = 15;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_BE_W    = DEF_DATA_W / 8;
    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned IDX_W       = 3;

    typedef logic [IDX_W-1:0] master_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from req and a rotating priority pointer.
module rr_arbiter
    import shared_mem_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   advance,
    output logic [NUM_MASTERS-1:0] grant,
    output master_idx_t            grant_idx
);

    master_idx_t rr_ptr;
    logic        found;

    // First pass covers rr_ptr..N-1, second pass wraps to 0..rr_ptr-1.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (!found && req[i] && (master_idx_t'(i) >= rr_ptr)) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = master_idx_t'(i);
            end
        end
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = master_idx_t'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_idx == master_idx_t'(NUM_MASTERS - 1)) ? '0
                                                                      : grant_idx + master_idx_t'(1);
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Shares one single-port memory between NUM_MASTERS Avalon-MM masters, one transfer per clock.
module shared_mem_arbiter
    import shared_mem_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
    input  logic [NUM_MASTERS-1:0]          m_read,
    input  logic [NUM_MASTERS-1:0]          m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
    output logic [NUM_MASTERS-1:0]          m_waitrequest,
    output logic [DATA_W-1:0]               m_readdata,
    output logic [NUM_MASTERS-1:0]          m_readdatavalid,
    output logic [ADDR_W-1:0]               mem_address,
    output logic [DATA_W/8-1:0]             mem_byteenable,
    output logic                            mem_chipselect,
    output logic                            mem_write,
    output logic [DATA_W-1:0]               mem_writedata,
    output logic                            mem_clken,
    input  logic [DATA_W-1:0]               mem_readdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] grant;
    master_idx_t            grant_idx;
    logic                   rd_accept;
    logic                   rd_vld;
    master_idx_t            rd_id;

    assign req = m_read | m_write;

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .advance   (|grant),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign m_waitrequest  = req & ~grant;
    assign mem_chipselect = |grant;
    assign mem_clken      = 1'b1;
    assign m_readdata     = mem_readdata;

    // Memory-side mux; a simultaneous read+write is treated as a write only.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_write      = 1'b0;
        rd_accept      = 1'b0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (grant[i]) begin
                mem_address    = m_address[i*ADDR_W +: ADDR_W];
                mem_byteenable = m_byteenable[i*BE_W +: BE_W];
                mem_writedata  = m_writedata[i*DATA_W +: DATA_W];
                mem_write      = m_write[i];
                rd_accept      = m_read[i] & ~m_write[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld <= 1'b0;
            rd_id  <= '0;
        end else begin
            rd_vld <= rd_accept;
            rd_id  <= grant_idx;
        end
    end

    always_comb begin
        m_readdatavalid = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            m_readdatavalid[i] = rd_vld && (rd_id == master_idx_t'(i));
        end
    end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench: 2-master instance with a memory model, plus a 4-master instance for rotation.
module tb_shared_mem_arbiter;

    typedef struct packed {
        logic [14:0] addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [1:0]  wreq;
    } gexp_t;

    typedef struct packed {
        logic [1:0]  vld;
        logic [31:0] data;
    } rexp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 2-master instance
    logic [29:0] m_address;
    logic [7:0]  m_byteenable;
    logic [1:0]  m_read, m_write;
    logic [63:0] m_writedata;
    logic [1:0]  m_waitrequest, m_readdatavalid;
    logic [31:0] m_readdata;
    logic [14:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    shared_mem_arbiter #(.NUM_MASTERS(2), .ADDR_W(15), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m_address(m_address), .m_byteenable(m_byteenable), .m_read(m_read),
        .m_write(m_write), .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // 4-master instance
    logic [59:0]  m_address4;
    logic [15:0]  m_byteenable4;
    logic [3:0]   m_read4, m_write4;
    logic [127:0] m_writedata4;
    logic [3:0]   m_waitrequest4, m_readdatavalid4;
    logic [31:0]  m_readdata4;
    logic [14:0]  mem_address4;
    logic [3:0]   mem_byteenable4;
    logic         mem_chipselect4, mem_write4, mem_clken4;
    logic [31:0]  mem_writedata4;
    logic [31:0]  mem_readdata4 = 32'h0;

    shared_mem_arbiter #(.NUM_MASTERS(4), .ADDR_W(15), .DATA_W(32)) dut4 (
        .clk(clk), .reset(reset),
        .m_address(m_address4), .m_byteenable(m_byteenable4), .m_read(m_read4),
        .m_write(m_write4), .m_writedata(m_writedata4), .m_waitrequest(m_waitrequest4),
        .m_readdata(m_readdata4), .m_readdatavalid(m_readdatavalid4),
        .mem_address(mem_address4), .mem_byteenable(mem_byteenable4),
        .mem_chipselect(mem_chipselect4), .mem_write(mem_write4),
        .mem_writedata(mem_writedata4), .mem_clken(mem_clken4), .mem_readdata(mem_readdata4)
    );

    // Single-port memory model with byte lanes and one-cycle read latency
    logic [31:0] mem [0:32767];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= mem[mem_address];
            end
        end
    end

    gexp_t gq[$];
    rexp_t rq[$];
    int    gq4[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic r, input logic w, input logic [14:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        m_read[i]                = r;
        m_write[i]               = w;
        m_address[i*15 +: 15]    = a;
        m_byteenable[i*4 +: 4]   = be;
        m_writedata[i*32 +: 32]  = d;
    endtask

    function automatic gexp_t ge(input logic [14:0] a, input logic w, input logic [3:0] be,
                                 input logic [31:0] d, input logic [1:0] wq);
        gexp_t g;
        g.addr = a; g.wr = w; g.be = be; g.wd = d; g.wreq = wq;
        return g;
    endfunction

    function automatic rexp_t re(input logic [1:0] v, input logic [31:0] d);
        rexp_t r;
        r.vld = v; r.data = d;
        return r;
    endfunction

    // Monitors: pop and compare whenever a DUT presents a grant or a read return
    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        if (mem_chipselect) begin
            if (gq.size() == 0) check("unexpected_grant", 128'(mem_address), 128'hx);
            else begin
                g = gq.pop_front();
                check("grant", 128'({mem_address, mem_write, mem_byteenable, mem_writedata, m_waitrequest}),
                      128'(g));
            end
        end
        if (m_readdatavalid != 2'b00) begin
            if (rq.size() == 0) check("unexpected_rdv", 128'(m_readdatavalid), 128'h0);
            else begin
                r = rq.pop_front();
                check("read_return", 128'({m_readdatavalid, m_readdata}), 128'(r));
            end
        end
    end

    always @(negedge clk) begin
        int id;
        if (mem_chipselect4) begin
            if (gq4.size() == 0) check("unexpected_grant4", 128'(mem_address4), 128'hx);
            else begin
                id = gq4.pop_front();
                check("grant4", 128'({mem_address4, mem_writedata4, m_waitrequest4}),
                      128'({15'(15'h100 + 15'(id)), 32'(id), 4'(4'hF & ~(4'h1 << id))}));
            end
        end
    end

    initial begin
        mem[1] = 32'h1111_1111;
        mem[2] = 32'h2222_2222;
        m_read = '0; m_write = '0; m_address = '0; m_byteenable = '0; m_writedata = '0;
        m_read4 = '0; m_write4 = '0; m_byteenable4 = '1;
        for (int i = 0; i < 4; i++) begin
            m_address4[i*15 +: 15]   = 15'(15'h100 + 15'(i));
            m_writedata4[i*32 +: 32] = 32'(i);
        end
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;

        // Reset then idle
        @(negedge clk);
        check("idle_rdv", 128'(m_readdatavalid), 128'h0);
        check("idle_cs", 128'(mem_chipselect), 128'h0);
        check("idle_wreq", 128'(m_waitrequest), 128'h0);
        check("idle_clken", 128'(mem_clken), 128'h1);
        check("idle_cs4", 128'(mem_chipselect4), 128'h0);

        // Single master write / read / byte-lane write / read / illegal read+write
        cyc(); set_m(0, 0, 1, 15'h10, 4'hF, 32'hDEAD_BEEF);
        gq.push_back(ge(15'h10, 1, 4'hF, 32'hDEAD_BEEF, 2'b00));
        cyc(); set_m(0, 1, 0, 15'h10, 4'hF, 32'h0);
        gq.push_back(ge(15'h10, 0, 4'hF, 32'h0, 2'b00));
        rq.push_back(re(2'b01, 32'hDEAD_BEEF));
        cyc(); set_m(0, 0, 1, 15'h10, 4'h1, 32'h0000_00AB);
        gq.push_back(ge(15'h10, 1, 4'h1, 32'h0000_00AB, 2'b00));
        cyc(); set_m(0, 1, 0, 15'h10, 4'hF, 32'h0);
        gq.push_back(ge(15'h10, 0, 4'hF, 32'h0, 2'b00));
        rq.push_back(re(2'b01, 32'hDEAD_BEAB));
        cyc(); set_m(0, 1, 1, 15'h20, 4'hF, 32'h1234_5678);
        gq.push_back(ge(15'h20, 1, 4'hF, 32'h1234_5678, 2'b00));
        cyc(); set_m(0, 0, 0, 15'h0, 4'hF, 32'h0);
        @(negedge clk);
        check("rw_no_rdv", 128'(m_readdatavalid), 128'h0);
        cyc();

        // Simultaneous reads from reset: master 0 first, master 1 stalls one cycle
        reset = 1'b1;
        cyc(); reset = 1'b0;
        set_m(0, 1, 0, 15'h1, 4'hF, 32'h0);
        set_m(1, 1, 0, 15'h2, 4'hF, 32'h0);
        gq.push_back(ge(15'h1, 0, 4'hF, 32'h0, 2'b10));
        rq.push_back(re(2'b01, 32'h1111_1111));
        cyc(); set_m(0, 0, 0, 15'h0, 4'hF, 32'h0);
        gq.push_back(ge(15'h2, 0, 4'hF, 32'h0, 2'b00));
        rq.push_back(re(2'b10, 32'h2222_2222));
        cyc(); set_m(1, 0, 0, 15'h0, 4'hF, 32'h0);
        repeat (2) cyc();

        // Reset in the cycle after a granted read kills the pending read and the pointer
        set_m(0, 1, 0, 15'h1, 4'hF, 32'h0);
        gq.push_back(ge(15'h1, 0, 4'hF, 32'h0, 2'b00));
        rq.push_back(re(2'b01, 32'h1111_1111));
        cyc(); reset = 1'b1;
        gq.push_back(ge(15'h1, 0, 4'hF, 32'h0, 2'b00));
        cyc(); reset = 1'b0;
        set_m(1, 1, 0, 15'h2, 4'hF, 32'h0);
        gq.push_back(ge(15'h1, 0, 4'hF, 32'h0, 2'b10));
        rq.push_back(re(2'b01, 32'h1111_1111));
        @(negedge clk);
        check("reset_kills_rdv", 128'(m_readdatavalid), 128'h0);
        cyc(); set_m(0, 0, 0, 15'h0, 4'hF, 32'h0);
        gq.push_back(ge(15'h2, 0, 4'hF, 32'h0, 2'b00));
        rq.push_back(re(2'b10, 32'h2222_2222));
        cyc(); set_m(1, 0, 0, 15'h0, 4'hF, 32'h0);
        repeat (2) cyc();

        // Four masters requesting continuously: strict rotation, no idle cycle
        m_write4 = 4'hF;
        for (int k = 0; k < 12; k++) gq4.push_back(k % 4);
        repeat (12) cyc();
        m_write4 = 4'h0;
        repeat (3) cyc();

        check("gq_drained", 128'(gq.size()), 128'h0);
        check("rq_drained", 128'(rq.size()), 128'h0);
        check("gq4_drained", 128'(gq4.size()), 128'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Round-robin arbiter that shares one single-port 32768×32 on-chip memory (15-bit word address, 4-bit byte enables, one-cycle read latency) between `NUM_MASTERS` processor data masters in the MPSoC. It grants at most one Avalon-MM transfer per clock, stalls the losers with `waitrequest`, and returns read data to the winner with `readdatavalid`. It sits between the interconnect master ports and the memory slave port.

## Interface
- `NUM_MASTERS`, 2: number of requesters, range 2..8.
- `ADDR_W`, 15: word address width; matches memory depth 32768.
- `DATA_W`, 32: data width; byte enable width is `DATA_W/8`.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m_address`  in  `NUM_MASTERS*ADDR_W`  per-master address, master i at slice i.
- `m_byteenable`  in  `NUM_MASTERS*DATA_W/8`  per-master byte enables.
- `m_read`  in  `NUM_MASTERS`  read request.
- `m_write`  in  `NUM_MASTERS`  write request.
- `m_writedata`  in  `NUM_MASTERS*DATA_W`  write data.
- `m_waitrequest`  out  `NUM_MASTERS`  1 = request not accepted this cycle.
- `m_readdata`  out  `DATA_W`  shared read-data bus, qualified per master.
- `m_readdatavalid`  out  `NUM_MASTERS`  one-cycle read return strobe.
- `mem_address`  out  `ADDR_W`  to memory.
- `mem_byteenable`  out  `DATA_W/8`  to memory.
- `mem_chipselect`  out  1  to memory.
- `mem_write`  out  1  to memory.
- `mem_writedata`  out  `DATA_W`  to memory.
- `mem_clken`  out  1  constant 1.
- `mem_readdata`  in  `DATA_W`  from memory, valid one cycle after the access.

## Operation
- Request: `req[i] = m_read[i] | m_write[i]`.
- Grant: combinational one-hot from `req` and registered pointer `rr_ptr`. The first requester at or after `rr_ptr`, scanning upward modulo `NUM_MASTERS`, wins.
- On a grant to master g:
  - `rr_ptr <= (g+1) mod NUM_MASTERS`.
  - No grant leaves `rr_ptr` unchanged.
- Waitrequest:
  - `m_waitrequest[i] = req[i] & ~grant[i]`.
  - Non-requesting masters see 0.
- Memory side:
  - `mem_*` follow the granted master's signals.
  - `mem_chipselect = |grant`.
  - `mem_write = m_write[g]`.
  - With no grant, `mem_address`, `mem_byteenable` and `mem_writedata` are driven 0.
- Read and write asserted together by one master is illegal. The write takes effect and no `readdatavalid` is produced.
- Read return:
  - Registers `rd_vld` and `rd_id` capture the granted read.
  - Next cycle, `m_readdatavalid[rd_id] = rd_vld` and `m_readdata = mem_readdata`.
- Writes produce no response.

## Timing
- Reset values:
  - `rr_ptr = 0`, `rd_vld = 0`.
  - All `m_readdatavalid` are 0.
  - `m_waitrequest` is purely combinational and depends only on requests and `rr_ptr`.
- Latency:
  - Granted in cycle T → accepted at the edge ending T.
  - Read data valid with `m_readdatavalid` high in T+1.
  - Back-to-back reads give full throughput: one transfer per cycle.
- A master holds its request stable until `waitrequest` is 0.
- Fairness: a continuously requesting master waits at most `NUM_MASTERS-1` cycles.
- `reset` asserted during a read: no `readdatavalid` in the following cycle, and `rr_ptr` returns to 0.
- Wrap-around: a grant to master `NUM_MASTERS-1` sets `rr_ptr` to 0.

## Structure
- Package `shared_mem_arb_pkg` holds:
  - default widths (`ADDR_W`, `DATA_W`),
  - `MAX_MASTERS = 8`,
  - master-index typedef (3 bits),
  - byte-enable width constant.
- Sub-module `rr_arbiter`, parameterized by `NUM_MASTERS`:
  - inputs: `req` vector and `advance`;
  - outputs: one-hot `grant` and encoded index;
  - owns `rr_ptr`.
- Top level holds the datapath muxing and the read-return register.

## Test plan
- Reset then idle: all `m_readdatavalid` 0, `mem_chipselect` 0, all `m_waitrequest` 0.
- Master 0 alone writes 0xDEADBEEF to 0x0010 with byteenable 0xF, then reads 0x0010 → no stall on either access; `m_readdatavalid[0]` one cycle after the read with data 0xDEADBEEF.
- Byte-lane write: 0x000000AB with byteenable 0x1 to 0x0010 (holding 0xDEADBEEF), then read back → 0xDEADBEAB.
- Masters 0 and 1 read 0x0001 and 0x0002 simultaneously from reset → master 0 granted first and master 1 stalls one cycle; returns arrive in consecutive cycles with correct `readdatavalid` routing.
- `NUM_MASTERS=4`, all masters request continuously for 12 cycles → grant order 0,1,2,3,0,1,2,3,0,1,2,3 with no idle cycle.
- `reset` pulsed in the cycle after a granted read → no `readdatavalid` next cycle; the next arbitration starts from master 0.
